// File: rtl/riscv_hart_scheduler_pkg.sv
// Shared multithreading definitions for the RI5CY MT core: hart count, hart-ID width
// and the per-stage slot type that the scheduler carries down ID/EX/WB.
package riscv_defines;

    localparam int NUM_THREADS       = 4;
    localparam int THREAD_ADDR_WIDTH = $clog2(NUM_THREADS);

    typedef struct packed {
        logic                         valid;
        logic [THREAD_ADDR_WIDTH-1:0] id;
    } hart_slot_t;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester after i_last,
// scanning upward with wrap-around. Generic enough for any MT arbitration point.
module riscv_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_eligible,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_grant,
    output logic         o_grant_valid
);

    // Cost of each requester = distance after i_last; ineligible ones get N (never wins).
    logic [W:0] w_cost [N];
    logic [W:0] w_best;

    for (genvar gi = 0; gi < N; gi++) begin : g_cost
        assign w_cost[gi] = i_eligible[gi]
                          ? (W+1)'((gi + N - 1 - int'(i_last)) % N)
                          : (W+1)'(N);
    end

    always_comb begin
        w_best        = (W+1)'(N);
        o_grant       = '0;
        o_grant_valid = 1'b0;
        for (int h = 0; h < N; h++) begin
            if (w_cost[h] < w_best) begin
                w_best        = w_cost[h];
                o_grant       = W'(h);
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_hart_scheduler.sv
// Fine-grained MT hart scheduler: round-robin pick into ID, then carries {id,valid} to EX/WB.
// Optional macro RISCV_MT_HART_EXCLUSIVE_EN keeps a hart out of ID while it still occupies ID or EX.
module riscv_hart_scheduler
    import riscv_defines::*;
#(
    parameter int NUM_THREADS       = riscv_defines::NUM_THREADS,
    parameter int THREAD_ADDR_WIDTH = riscv_defines::THREAD_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_THREADS-1:0]       hart_active_i,
    input  logic [NUM_THREADS-1:0]       hart_stall_i,
    input  logic                         advance_i,
    input  logic [NUM_THREADS-1:0]       flush_i,
    output logic [THREAD_ADDR_WIDTH-1:0] hart_id_o,
    output logic                         hart_valid_o,
    output logic [THREAD_ADDR_WIDTH-1:0] hart_id_ex_o,
    output logic                         hart_valid_ex_o,
    output logic [THREAD_ADDR_WIDTH-1:0] hart_id_wb_o,
    output logic                         hart_valid_wb_o
);

    typedef struct packed {
        logic                         valid;
        logic [THREAD_ADDR_WIDTH-1:0] id;
    } slot_t;

    slot_t                         r_id_slot;
    slot_t                         r_ex_slot;
    slot_t                         r_wb_slot;
    logic [THREAD_ADDR_WIDTH-1:0]  r_last;

    logic [NUM_THREADS-1:0]        w_busy;
    logic [NUM_THREADS-1:0]        w_eligible;
    logic [THREAD_ADDR_WIDTH-1:0]  w_pick;
    logic                          w_pick_valid;

    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_elig
`ifdef RISCV_MT_HART_EXCLUSIVE_EN
        // Current ID/EX occupants land in EX/WB after the shift; one stage per hart at a time.
        assign w_busy[gi] = (r_id_slot.valid && (r_id_slot.id == THREAD_ADDR_WIDTH'(gi)))
                         || (r_ex_slot.valid && (r_ex_slot.id == THREAD_ADDR_WIDTH'(gi)));
`else
        assign w_busy[gi] = 1'b0;
`endif
        assign w_eligible[gi] = hart_active_i[gi] & ~hart_stall_i[gi]
                              & ~flush_i[gi] & ~w_busy[gi];
    end

    riscv_rr_arbiter #(
        .N (NUM_THREADS),
        .W (THREAD_ADDR_WIDTH)
    ) u_arbiter (
        .i_eligible    (w_eligible),
        .i_last        (r_last),
        .o_grant       (w_pick),
        .o_grant_valid (w_pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_slot <= '0;
            r_ex_slot <= '0;
            r_wb_slot <= '0;
            r_last    <= THREAD_ADDR_WIDTH'(NUM_THREADS - 1);
        end else if (advance_i) begin
            // WB is committing and never flushed; the entry moving into EX is.
            r_wb_slot       <= r_ex_slot;
            r_ex_slot.id    <= r_id_slot.id;
            r_ex_slot.valid <= r_id_slot.valid & ~flush_i[r_id_slot.id];
            if (w_pick_valid) begin
                r_id_slot.id    <= w_pick;
                r_id_slot.valid <= 1'b1;
                r_last          <= w_pick;
            end else begin
                r_id_slot.valid <= 1'b0;
            end
        end
    end

    assign hart_id_o       = r_id_slot.id;
    assign hart_valid_o    = r_id_slot.valid;
    assign hart_id_ex_o    = r_ex_slot.id;
    assign hart_valid_ex_o = r_ex_slot.valid;
    assign hart_id_wb_o    = r_wb_slot.id;
    assign hart_valid_wb_o = r_wb_slot.valid;

endmodule
